// File: rtl/clint_ctrl_if.sv
// Bundle between the trap controller and the decode stage, CSR file and fetch.
// master = the trap controller; slave = the pipeline/CSR side.
interface clint_ctrl_if;
  logic        I_inst_valid;
  logic        I_inst_ecall;
  logic        I_inst_ebreak;
  logic        I_inst_mret;
  logic [31:0] I_inst_addr;
  logic        I_int_flag;
  logic [31:0] I_csr_mtvec;
  logic [31:0] I_csr_mepc;
  logic [31:0] I_csr_mstatus;
  logic        I_global_int_en;
  logic        O_we;
  logic [11:0] O_waddr;
  logic [31:0] O_wdata;
  logic        O_hold_flag;
  logic        O_int_assert;
  logic [31:0] O_int_addr;

  modport master (
    input  I_inst_valid, I_inst_ecall, I_inst_ebreak, I_inst_mret, I_inst_addr,
    input  I_int_flag, I_csr_mtvec, I_csr_mepc, I_csr_mstatus, I_global_int_en,
    output O_we, O_waddr, O_wdata, O_hold_flag, O_int_assert, O_int_addr
  );

  modport slave (
    output I_inst_valid, I_inst_ecall, I_inst_ebreak, I_inst_mret, I_inst_addr,
    output I_int_flag, I_csr_mtvec, I_csr_mepc, I_csr_mstatus, I_global_int_en,
    input  O_we, O_waddr, O_wdata, O_hold_flag, O_int_assert, O_int_addr
  );
endinterface

// File: rtl/clint_ctrl.sv
// Core-local trap controller: saves mepc/mcause/mstatus on a trap, restores
// mstatus on mret, stalls the pipeline meanwhile and redirects fetch.
module clint_ctrl (
  input  logic         clk,
  input  logic         rst,
  clint_ctrl_if.master bus,
  output logic [2:0]   O_dbg_state
);
  // Handshake: no valid/ready; a trigger is consumed in the IDLE cycle it is
  // seen, and O_hold_flag stalls decode until the sequence finishes.

  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;

  localparam logic [31:0] CAUSE_ECALL  = 32'd11;
  localparam logic [31:0] CAUSE_EBREAK = 32'd3;
  localparam logic [31:0] CAUSE_IRQ    = 32'h8000_000B;

  typedef enum logic [2:0] {
    IDLE            = 3'd0,
    SAVE_MEPC       = 3'd1,
    SAVE_MCAUSE     = 3'd2,
    SAVE_MSTATUS    = 3'd3,
    JUMP_TRAP       = 3'd4,
    RESTORE_MSTATUS = 3'd5,
    JUMP_RET        = 3'd6
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] epc_q, epc_d;
  logic [31:0] cause_q, cause_d;

  logic        exc_trig, mret_trig, irq_trig, any_trig;
  logic        we;
  logic [11:0] waddr;
  logic [31:0] wdata;
  logic        hold;
  logic        int_assert;
  logic [31:0] int_addr;

  always_comb begin
    exc_trig  = bus.I_inst_valid & (bus.I_inst_ecall | bus.I_inst_ebreak);
    mret_trig = bus.I_inst_valid & bus.I_inst_mret;
    irq_trig  = bus.I_int_flag & bus.I_global_int_en;
    any_trig  = exc_trig | mret_trig | irq_trig;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      epc_q   <= '0;
      cause_q <= '0;
    end else begin
      state_q <= state_d;
      epc_q   <= epc_d;
      cause_q <= cause_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    epc_d      = epc_q;
    cause_d    = cause_q;
    we         = 1'b0;
    waddr      = '0;
    wdata      = '0;
    hold       = 1'b1;
    int_assert = 1'b0;
    int_addr   = '0;

    case (state_q)
      IDLE: begin
        hold = any_trig;
        if (exc_trig) begin
          state_d = SAVE_MEPC;
          epc_d   = bus.I_inst_addr;
          cause_d = bus.I_inst_ecall ? CAUSE_ECALL : CAUSE_EBREAK;
        end else if (mret_trig) begin
          state_d = RESTORE_MSTATUS;
        end else if (irq_trig) begin
          // Interrupt resumes at the decode instruction, which has not run yet.
          state_d = SAVE_MEPC;
          epc_d   = bus.I_inst_addr;
          cause_d = CAUSE_IRQ;
        end
      end
      SAVE_MEPC: begin
        we      = 1'b1;
        waddr   = CSR_MEPC;
        wdata   = epc_q;
        state_d = SAVE_MCAUSE;
      end
      SAVE_MCAUSE: begin
        we      = 1'b1;
        waddr   = CSR_MCAUSE;
        wdata   = cause_q;
        state_d = SAVE_MSTATUS;
      end
      SAVE_MSTATUS: begin
        we       = 1'b1;
        waddr    = CSR_MSTATUS;
        wdata    = bus.I_csr_mstatus;
        wdata[7] = bus.I_csr_mstatus[3];
        wdata[3] = 1'b0;
        state_d  = JUMP_TRAP;
      end
      JUMP_TRAP: begin
        int_assert = 1'b1;
        int_addr   = bus.I_csr_mtvec & ~32'h3;
        state_d    = IDLE;
      end
      RESTORE_MSTATUS: begin
        we       = 1'b1;
        waddr    = CSR_MSTATUS;
        wdata    = bus.I_csr_mstatus;
        wdata[3] = bus.I_csr_mstatus[7];
        wdata[7] = 1'b1;
        state_d  = JUMP_RET;
      end
      JUMP_RET: begin
        int_assert = 1'b1;
        int_addr   = bus.I_csr_mepc;
        state_d    = IDLE;
      end
      default: begin
        hold    = 1'b0;
        state_d = IDLE;
      end
    endcase

    // Reset silences every output in its own cycle so an abandoned sequence
    // can neither write a CSR nor redirect fetch.
    if (rst) begin
      we         = 1'b0;
      waddr      = '0;
      wdata      = '0;
      hold       = 1'b0;
      int_assert = 1'b0;
      int_addr   = '0;
    end
  end

  assign bus.O_we         = we;
  assign bus.O_waddr      = waddr;
  assign bus.O_wdata      = wdata;
  assign bus.O_hold_flag  = hold;
  assign bus.O_int_assert = int_assert;
  assign bus.O_int_addr   = int_addr;
  assign O_dbg_state      = state_q;
endmodule

// File: doc/clint_ctrl.md
# clint_ctrl

Core-local trap controller that sequences the CSR register file on exceptions, external interrupts and `mret`. It sits beside the decode/execute stages and drives the CSR file's dedicated controller write port, which has priority over core CSR writes. It stalls the pipeline while it saves or restores machine state, then redirects fetch to `mtvec` or `mepc`.

## Interface
- `CSR_MSTATUS`, 12'h300: mstatus address.
- `CSR_MEPC`, 12'h341: mepc address.
- `CSR_MCAUSE`, 12'h342: mcause address.
- `clk`  in  1  clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `I_inst_valid`  in  1  decode-stage instruction is valid; qualifies the next three inputs.
- `I_inst_ecall`  in  1  decode-stage instruction is `ecall`.
- `I_inst_ebreak`  in  1  decode-stage instruction is `ebreak`.
- `I_inst_mret`  in  1  decode-stage instruction is `mret`.
- `I_inst_addr`  in  32  PC of the decode-stage instruction.
- `I_int_flag`  in  1  external interrupt request, level-sensitive.
- `I_csr_mtvec`  in  32  current mtvec.
- `I_csr_mepc`  in  32  current mepc.
- `I_csr_mstatus`  in  32  current mstatus.
- `I_global_int_en`  in  1  mstatus.MIE (bit 3).
- `O_we`  out  1  controller CSR write enable.
- `O_waddr`  out  12  controller CSR write address.
- `O_wdata`  out  32  controller CSR write data.
- `O_hold_flag`  out  1  pipeline stall request.
- `O_int_assert`  out  1  one-cycle fetch redirect strobe.
- `O_int_addr`  out  32  redirect target; valid only while `O_int_assert` is 1.

## Operation
- States: IDLE, SAVE_MEPC, SAVE_MCAUSE, SAVE_MSTATUS, JUMP_TRAP, RESTORE_MSTATUS, JUMP_RET.
- Trigger sampling happens only in IDLE. Priority, highest first:
  - sync exception: `I_inst_valid & (ecall|ebreak)`;
  - mret: `I_inst_valid & mret`;
  - external interrupt: `I_int_flag & I_global_int_en`.
- If `ecall` and `ebreak` are both asserted, `ecall` wins.
- On a trap trigger in IDLE, the controller latches two values and moves to SAVE_MEPC:
  - epc = `I_inst_addr`. For an interrupt this is the PC of the not-yet-executed decode instruction.
  - cause = 32'd11 for ecall, 32'd3 for ebreak, 32'h8000_000B for interrupt.
- On mret in IDLE, the controller moves to RESTORE_MSTATUS.
- SAVE_MEPC: write `CSR_MEPC` with the latched epc, then go to SAVE_MCAUSE.
- SAVE_MCAUSE: write `CSR_MCAUSE` with the latched cause, then go to SAVE_MSTATUS.
- SAVE_MSTATUS: write `CSR_MSTATUS` with `I_csr_mstatus`, modified so bit7 (MPIE) = old bit3 and bit3 (MIE) = 0; all other bits unchanged. Then go to JUMP_TRAP.
- JUMP_TRAP: `O_int_assert`=1, `O_int_addr` = `I_csr_mtvec & ~32'h3` (direct mode only). Then go to IDLE.
- RESTORE_MSTATUS: write `CSR_MSTATUS` with bit3 = old bit7 and bit7 = 1. Then go to JUMP_RET.
- JUMP_RET: `O_int_assert`=1, `O_int_addr` = `I_csr_mepc`. Then go to IDLE.
- In every state without a write, `O_we`=0, `O_waddr`=0 and `O_wdata`=0.
- The interrupt is not latched. If `I_int_flag` drops before an IDLE sample, the interrupt is lost. An interrupt that is held asserted across a trap is taken on the first IDLE cycle where `I_global_int_en`=1.
- mstatus is never written before SAVE_MSTATUS within a sequence, so the registered `I_csr_mstatus` is current at that point.

## Timing
- Reset: state = IDLE, epc = 0, cause = 0. All outputs are 0 except combinational `O_hold_flag`, which evaluates to 0 while `rst` is held.
- `O_hold_flag` = (state != IDLE) | (IDLE & any trigger). It is combinational, so the stall covers the detect cycle.
- Trap latency: detect in cycle 0, CSR writes in cycles 1–3, redirect in cycle 4. Hold is 1 for cycles 0–4 and 0 in cycle 5.
- mret latency: detect in cycle 0, write in cycle 1, redirect in cycle 2. Hold is 1 for cycles 0–2.
- Each CSR write commits at the end of its cycle, so the CSR file shows the new value from the next cycle.
- Reset asserted mid-sequence forces IDLE on the next edge and abandons any remaining writes. `O_int_assert` must not pulse.
- Back-to-back sequences: the cycle after JUMP_* is IDLE and samples triggers again. Decode inputs in that cycle must already reflect the redirected stream; this is the pipeline's responsibility.

## Test plan
- Exception: ecall at PC 0x8000_0010, mtvec = 0x8000_0103, mstatus = 0x8 → mepc = 0x8000_0010, mcause = 11, mstatus = 0x80; one `O_int_assert` pulse in cycle 4 with addr 0x8000_0100; hold high for exactly 5 cycles.
- Return: mret with mepc = 0x8000_0014, mstatus = 0x80 → mstatus = 0x88; redirect to 0x8000_0014 in cycle 2; hold high for exactly 3 cycles.
- Interrupt gating: `I_int_flag`=1 with `I_global_int_en`=0 for 10 cycles → no write, no hold. Raise the enable → mcause = 0x8000_000B, mepc = `I_inst_addr` sampled at detect.
- Priority: ecall + mret + interrupt asserted in the same IDLE cycle → exception sequence only, cause 11. ecall + ebreak together → cause 11.
- Busy masking: pulse `I_int_flag` for one cycle during SAVE_MCAUSE → ignored; sequence completes unchanged.
- Reset mid-trap: assert `rst` in SAVE_MCAUSE → next cycle IDLE, `O_we`=0, no `O_int_assert`; mstatus is left unwritten.
